// File: rtl/hedios_pkg.sv
// Shared definitions for the Hedios packet transmitter.
//   hedios_state_e      : frame sequencer states
//   HEDIOS_SYNC_DEFAULT : default sync header byte
//   hedios_frame_bytes  : bytes on the line per frame
//   hedios_frame_cycles : clock cycles a frame occupies on the line
package hedios_pkg;

  localparam logic [7:0] HEDIOS_SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSendHdr,
    StSendCmd,
    StSendData,
    StSendCsum,
    StGap
  } hedios_state_e;

  // Sync + command + payload (+ optional checksum).
  function automatic int unsigned hedios_frame_bytes(input int unsigned data_bytes,
                                                     input bit          csum_en);
    return 2 + data_bytes + (csum_en ? 1 : 0);
  endfunction

  // Each byte is 10 bit-times (start, 8 data, stop).
  function automatic int unsigned hedios_frame_cycles(input int unsigned data_bytes,
                                                      input bit          csum_en,
                                                      input int unsigned bit_cycles);
    return hedios_frame_bytes(data_bytes, csum_en) * 10 * bit_cycles;
  endfunction

endpackage

// File: rtl/hedios_uart_tx_core.sv
// 8N1 UART byte serialiser with a one-byte holding register.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   byte_i         : byte offered by the sequencer
//   byte_valid_i   : byte_i is valid
//   byte_ready_o   : holding register empty; a valid byte is taken this cycle
//   tx_o           : registered serial line, idle high
//   byte_done_o    : stop bit of the byte in the shifter completes this cycle
// A byte offered while the shifter is free goes straight into the shifter, so
// the start bit appears on the edge that accepts it. While a byte is shifting,
// the next one waits in the holding register and follows with no idle bits.
module hedios_uart_tx_core #(
  parameter int unsigned BitCycles = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       tx_o,
  output logic       byte_done_o
);

  localparam int unsigned CntW = $clog2(BitCycles);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            active_q, active_d;
  logic            tx_q, tx_d;

  logic bit_end;
  logic last_bit;
  logic shifter_free;
  logic accept;

  assign accept       = byte_valid_i & ~hold_full_q;
  assign bit_end      = active_q && (cnt_q == CntW'(BitCycles - 1));
  // Bit index 0 is the start bit, 1..8 data, 9 the stop bit.
  assign last_bit     = bit_end && (bit_idx_q == 4'd9);
  assign shifter_free = ~active_q | last_bit;

  assign byte_ready_o = ~hold_full_q;
  assign tx_o         = tx_q;
  assign byte_done_o  = last_bit;

  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    tx_d        = tx_q;

    if (active_q) begin
      if (bit_end) begin
        cnt_d     = '0;
        bit_idx_d = bit_idx_q + 4'd1;
        // The bit following index n is data bit n, except after data bit 7.
        tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : shift_q[bit_idx_q[2:0]];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (accept) begin
      hold_d      = byte_i;
      hold_full_d = 1'b1;
    end

    if (shifter_free) begin
      if (hold_full_q || accept) begin
        shift_d     = hold_full_q ? hold_q : byte_i;
        hold_full_d = 1'b0;
        active_d    = 1'b1;
        cnt_d       = '0;
        bit_idx_d   = '0;
        tx_d        = 1'b0;
      end else begin
        active_d = 1'b0;
        tx_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: rtl/hedios_frame_tx.sv
// Hedios packet transmitter: queues command/data packets and sends each as a
// framed 8N1 byte stream: SYNC_BYTE, command, payload LSB byte first and,
// when HEDIOS_TX_CHECKSUM_EN is defined, an XOR checksum of command+payload.
//   clk, rst        : clock, synchronous active-high reset
//   packet_command  : command byte of the pushed packet
//   packet_data     : payload of the pushed packet
//   push_packet     : one-cycle enqueue strobe
//   queue_full      : FIFO holds FIFO_DEPTH packets
//   queue_empty     : FIFO holds no packets
//   queue_level     : packets currently queued
//   tx_line         : serial output, idle high
//   busy            : a frame is loaded, transmitting or in its gap
//   packet_sent     : frames fully transmitted, wraps
//   drop_count      : pushes rejected while full, saturates at 255
module hedios_frame_tx
  import hedios_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 1_000_000,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAP_BITS   = 2,
  parameter logic [7:0]  SYNC_BYTE  = HEDIOS_SYNC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    packet_command,
  input  logic [8*DATA_BYTES-1:0]       packet_data,
  input  logic                          push_packet,
  output logic                          queue_full,
  output logic                          queue_empty,
  output logic [$clog2(FIFO_DEPTH):0]   queue_level,
  output logic                          tx_line,
  output logic                          busy,
  output logic [15:0]                   packet_sent,
  output logic [7:0]                    drop_count
);

  localparam int unsigned BitCycles = CLK_RATE / BAUD_RATE;
  localparam int unsigned AddrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW      = AddrW + 1;
  localparam int unsigned DataW     = 8 * DATA_BYTES;
  localparam int unsigned IdxW      = $clog2(DATA_BYTES + 1);
  localparam int unsigned GapCycles = GAP_BITS * BitCycles;
  // A zero-length gap still spends one cycle in StGap.
  localparam int unsigned GapLast   = (GapCycles == 0) ? 0 : GapCycles - 1;
  localparam int unsigned GapW      = $clog2(GapLast + 2);

  // ---------------------------------------------------------------------------
  // Packet FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       cmd_mem  [FIFO_DEPTH];
  logic [DataW-1:0] data_mem [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] level_q, level_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;

  logic             do_push;
  logic             do_pop;
  logic             drop;
  logic [7:0]       head_cmd;
  logic [DataW-1:0] head_data;

  hedios_state_e state_q, state_d;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push   = push_packet & ~full_q;
  assign drop      = push_packet & full_q;
  assign do_pop    = (state_q == StLoad);
  assign head_cmd  = cmd_mem[rd_ptr_q[AddrW-1:0]];
  assign head_data = data_mem[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    level_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[PtrW-1] != rd_ptr_d[PtrW-1]) &&
               (wr_ptr_d[AddrW-1:0] == rd_ptr_d[AddrW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      cmd_mem[wr_ptr_q[AddrW-1:0]]  <= packet_command;
      data_mem[wr_ptr_q[AddrW-1:0]] <= packet_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  logic [7:0]      frame_cmd_q, frame_cmd_d;
  logic [DataW-1:0] frame_data_q, frame_data_d;
  logic [IdxW-1:0] byte_idx_q, byte_idx_d;
  logic            drain_q, drain_d;  // last byte handed off, awaiting its stop bit
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            busy_q;
  logic [15:0]     packet_sent_q;
  logic [7:0]      drop_q;

  logic       core_valid;
  logic [7:0] core_byte;
  logic       core_ready;
  logic       core_done;
  logic       tx_done;
  logic       frame_done;

  // The frame is over once the shifter finishes with nothing left queued.
  assign tx_done = core_done & core_ready;

`ifdef HEDIOS_TX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic [7:0] head_csum;

  always_comb begin
    head_csum = head_cmd;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      head_csum = head_csum ^ head_data[8*i +: 8];
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    frame_cmd_d  = frame_cmd_q;
    frame_data_d = frame_data_q;
    byte_idx_d   = byte_idx_q;
    drain_d      = drain_q;
    gap_cnt_d    = gap_cnt_q;
`ifdef HEDIOS_TX_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    core_valid   = 1'b0;
    core_byte    = SYNC_BYTE;
    frame_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty_q) state_d = StLoad;
      end
      StLoad: begin
        frame_cmd_d  = head_cmd;
        frame_data_d = head_data;
        byte_idx_d   = '0;
        drain_d      = 1'b0;
`ifdef HEDIOS_TX_CHECKSUM_EN
        csum_d       = head_csum;
`endif
        state_d      = StSendHdr;
      end
      StSendHdr: begin
        core_valid = 1'b1;
        core_byte  = SYNC_BYTE;
        if (core_ready) state_d = StSendCmd;
      end
      StSendCmd: begin
        core_valid = 1'b1;
        core_byte  = frame_cmd_q;
        if (core_ready) state_d = StSendData;
      end
      StSendData: begin
        if (!drain_q) begin
          core_valid = 1'b1;
          core_byte  = frame_data_q[7:0];
          if (core_ready) begin
            frame_data_d = frame_data_q >> 8;
            if (byte_idx_q == IdxW'(DATA_BYTES - 1)) begin
`ifdef HEDIOS_TX_CHECKSUM_EN
              state_d = StSendCsum;
`else
              drain_d = 1'b1;
`endif
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end
        end else if (tx_done) begin
          state_d    = StGap;
          gap_cnt_d  = '0;
          frame_done = 1'b1;
        end
      end
`ifdef HEDIOS_TX_CHECKSUM_EN
      StSendCsum: begin
        if (!drain_q) begin
          core_valid = 1'b1;
          core_byte  = csum_q;
          if (core_ready) drain_d = 1'b1;
        end else if (tx_done) begin
          state_d    = StGap;
          gap_cnt_d  = '0;
          frame_done = 1'b1;
        end
      end
`endif
      StGap: begin
        if (gap_cnt_q == GapW'(GapLast)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      frame_cmd_q   <= '0;
      frame_data_q  <= '0;
      byte_idx_q    <= '0;
      drain_q       <= 1'b0;
      gap_cnt_q     <= '0;
      busy_q        <= 1'b0;
      packet_sent_q <= '0;
      drop_q        <= '0;
`ifdef HEDIOS_TX_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      frame_cmd_q  <= frame_cmd_d;
      frame_data_q <= frame_data_d;
      byte_idx_q   <= byte_idx_d;
      drain_q      <= drain_d;
      gap_cnt_q    <= gap_cnt_d;
      busy_q       <= (state_d != StIdle);
`ifdef HEDIOS_TX_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      if (frame_done) packet_sent_q <= packet_sent_q + 16'd1;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  hedios_uart_tx_core #(
    .BitCycles(BitCycles)
  ) u_core (
    .clk_i       (clk),
    .rst_i       (rst),
    .byte_i      (core_byte),
    .byte_valid_i(core_valid),
    .byte_ready_o(core_ready),
    .tx_o        (tx_line),
    .byte_done_o (core_done)
  );

  assign queue_full  = full_q;
  assign queue_empty = empty_q;
  assign queue_level = level_q;
  assign busy        = busy_q;
  assign packet_sent = packet_sent_q;
  assign drop_count  = drop_q;

endmodule
